// File: rtl/m_stcmd_pkg.sv
// rtl/m_stcmd_pkg.sv - shared blitter command-sequencer types and constants
package m_stcmd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CMDF, ST_PARF, ST_GO} state_e;
  localparam int         PC_W     = 20;
  localparam int         PAR_CNT  = 12;
  localparam logic [7:0] CMD_HALT = 8'h00;
endpackage

// File: rtl/m_stcmd_stpcnt.sv
// rtl/m_stcmd_stpcnt.sv - loadable wrapping program counter with async clear
module m_stpcnt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld)       cnt_d = ld_val;
    else if (inc) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/m_stcmd.sv
// rtl/m_stcmd.sv - blitter command/parameter fetch sequencer
// Optional STCMD_PARSKIP_EN: odd nonzero commands skip the parameter fetch.
module m_stcmd
  import m_stcmd_pkg::*;
(
  input  logic            CCLK,
  input  logic            RESETL,
  input  logic            START,
  input  logic            ABORT,
  input  logic [PC_W-1:0] PCIN,
  input  logic [7:0]      DATA,
  input  logic            CYCEND,
  input  logic            PCEN,
  input  logic            UPDPCL,
  input  logic            INDONE,
  output logic            COMCRQ,
  output logic            PARCRQ,
  output logic [PC_W-1:0] PC,
  output logic [7:0]      CMD,
  output logic [7:0]      PARD,
  output logic [3:0]      PARIDX,
  output logic            PARLD,
  output logic            INSTART,
  output logic            RUN
);
  state_e     state_q, state_d;
  logic       comcrq_q, comcrq_d, parcrq_q, parcrq_d;
  logic [7:0] cmd_q, cmd_d, pard_q, pard_d;
  logic [3:0] paridx_q, paridx_d, cnt_q, cnt_d;
  logic       parld_q, parld_d, instart_q, instart_d, run_q, run_d;
  logic       pc_ld, pc_inc, prog_cyc, par_skip;

  assign prog_cyc = CYCEND & PCEN;
`ifdef STCMD_PARSKIP_EN
  assign par_skip = DATA[0];
`else
  assign par_skip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    comcrq_d  = comcrq_q;
    parcrq_d  = parcrq_q;
    cmd_d     = cmd_q;
    pard_d    = pard_q;
    paridx_d  = paridx_q;
    cnt_d     = cnt_q;
    parld_d   = 1'b0;
    instart_d = 1'b0;
    run_d     = run_q;
    pc_ld     = 1'b0;
    pc_inc    = (state_q != ST_IDLE) && !UPDPCL && !ABORT;
    if (ABORT) begin
      state_d  = ST_IDLE;
      comcrq_d = 1'b0;
      parcrq_d = 1'b0;
      run_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (START) begin
          pc_ld    = 1'b1;
          run_d    = 1'b1;
          comcrq_d = 1'b1;
          state_d  = ST_CMDF;
        end
        ST_CMDF: begin
          comcrq_d = 1'b1;
          if (prog_cyc) begin
            cmd_d    = DATA;
            comcrq_d = 1'b0;
            if (DATA == CMD_HALT) begin
              state_d = ST_IDLE;
              run_d   = 1'b0;
            end else if (par_skip) begin
              state_d   = ST_GO;
              instart_d = 1'b1;
            end else begin
              state_d  = ST_PARF;
              paridx_d = 4'd0;
              cnt_d    = 4'd0;
              parcrq_d = 1'b1;
            end
          end
        end
        ST_PARF: begin
          // Request drops on every program cycle end and returns a tick later.
          parcrq_d = 1'b1;
          if (prog_cyc) begin
            parcrq_d = 1'b0;
            pard_d   = DATA;
            parld_d  = 1'b1;
            paridx_d = cnt_q;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'(PAR_CNT - 1)) begin
              state_d   = ST_GO;
              instart_d = 1'b1;
            end
          end
        end
        ST_GO: if (INDONE) begin
          state_d  = ST_CMDF;
          comcrq_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CCLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q   <= ST_IDLE;
      comcrq_q  <= 1'b0;
      parcrq_q  <= 1'b0;
      cmd_q     <= 8'h00;
      pard_q    <= 8'h00;
      paridx_q  <= 4'd0;
      cnt_q     <= 4'd0;
      parld_q   <= 1'b0;
      instart_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      comcrq_q  <= comcrq_d;
      parcrq_q  <= parcrq_d;
      cmd_q     <= cmd_d;
      pard_q    <= pard_d;
      paridx_q  <= paridx_d;
      cnt_q     <= cnt_d;
      parld_q   <= parld_d;
      instart_q <= instart_d;
      run_q     <= run_d;
    end
  end

  m_stpcnt #(.W(PC_W)) u_pc (
    .clk    (CCLK),
    .rst_n  (RESETL),
    .ld     (pc_ld),
    .ld_val (PCIN),
    .inc    (pc_inc),
    .q      (PC)
  );

  assign COMCRQ  = comcrq_q;
  assign PARCRQ  = parcrq_q;
  assign CMD     = cmd_q;
  assign PARD    = pard_q;
  assign PARIDX  = paridx_q;
  assign PARLD   = parld_q;
  assign INSTART = instart_q;
  assign RUN     = run_q;
endmodule

// File: tb/tb_m_stcmd.sv
// tb/tb_m_stcmd.sv - directed scoreboard bench for m_stcmd
module tb_m_stcmd;
`ifdef STCMD_PARSKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic        CCLK = 1'b0, RESETL = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic        CYCEND = 1'b0, PCEN = 1'b0, UPDPCL = 1'b1, INDONE = 1'b0;
  logic [19:0] PCIN = '0;
  logic [7:0]  DATA = '0;
  logic        COMCRQ, PARCRQ, PARLD, INSTART, RUN;
  logic [19:0] PC;
  logic [7:0]  CMD, PARD;
  logic [3:0]  PARIDX;

  int errors = 0, checks = 0;
  int instart_cnt = 0, parld_cnt = 0, parcrq_cycles = 0;
  logic [11:0] sb[$];

  m_stcmd dut (
    .CCLK(CCLK), .RESETL(RESETL), .START(START), .ABORT(ABORT), .PCIN(PCIN),
    .DATA(DATA), .CYCEND(CYCEND), .PCEN(PCEN), .UPDPCL(UPDPCL), .INDONE(INDONE),
    .COMCRQ(COMCRQ), .PARCRQ(PARCRQ), .PC(PC), .CMD(CMD), .PARD(PARD),
    .PARIDX(PARIDX), .PARLD(PARLD), .INSTART(INSTART), .RUN(RUN)
  );

  always #5 CCLK = ~CCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CCLK) if (RESETL) begin
    if (INSTART) instart_cnt++;
    if (PARCRQ) parcrq_cycles++;
    if (PARLD) begin
      parld_cnt++;
      check("parld_expected", sb.size() > 0, 1);
      if (sb.size() > 0) check("parld_idx_data", {PARIDX, PARD}, sb.pop_front());
    end
  end

  task automatic mem_cycle(input logic [7:0] d, input bit is_par, input int idx);
    int n = 0;
    while (((is_par ? PARCRQ : COMCRQ) !== 1'b1) && n < 20) begin
      @(negedge CCLK);
      n++;
    end
    check(is_par ? "par_req_wait" : "cmd_req_wait", n < 20, 1);
    if (is_par) sb.push_back({4'(idx), d});
    CYCEND = 1'b1; PCEN = 1'b1; UPDPCL = 1'b0; DATA = d;
    @(negedge CCLK);
    CYCEND = 1'b0; PCEN = 1'b0; UPDPCL = 1'b1;
  endtask

  task automatic start_prog(input logic [19:0] pc);
    PCIN = pc; START = 1'b1;
    @(negedge CCLK);
    START = 1'b0;
    check("start_run", RUN, 1);
    check("start_pc", PC, pc);
    check("start_comcrq", COMCRQ, 1);
  endtask

  task automatic prog_body(input logic [19:0] base, input logic [7:0] c);
    int npar;
    logic [19:0] pc_exp;
    start_prog(base);
    instart_cnt = 0; parld_cnt = 0; parcrq_cycles = 0;
    mem_cycle(c, 1'b0, 0);
    check("cmd_latch", CMD, c);
    check("comcrq_drop", COMCRQ, 0);
    npar = (SKIP && c[0]) ? 0 : 12;
    if (npar > 0) begin
      CYCEND = 1'b1; PCEN = 1'b0; DATA = 8'hEE;
      @(negedge CCLK);
      CYCEND = 1'b0;
      check("nonprog_parcrq_held", PARCRQ, 1);
    end
    for (int i = 0; i < npar; i++) mem_cycle(8'(i + 1), 1'b1, i);
    repeat (2) @(negedge CCLK);
    pc_exp = base + 20'(npar) + 20'd1;
    check("parld_count", parld_cnt, npar);
    check("instart_count", instart_cnt, 1);
    check("pc_after_prog", PC, pc_exp);
    check("parcrq_none", parcrq_cycles == 0, npar == 0);
    check("sb_empty", sb.size(), 0);
    PCIN = 20'hAAAAA; START = 1'b1;
    @(negedge CCLK);
    START = 1'b0;
    check("start_ignored_pc", PC, pc_exp);
    check("go_comcrq_low", COMCRQ, 0);
    INDONE = 1'b1;
    @(negedge CCLK);
    INDONE = 1'b0;
    check("indone_comcrq", COMCRQ, 1);
    mem_cycle(8'h00, 1'b0, 0);
    check("halt_run", RUN, 0);
    check("halt_pc", PC, pc_exp + 20'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CCLK);
    check("reset_outputs", {COMCRQ, PARCRQ, PARLD, INSTART, RUN, PC, CMD, PARD, PARIDX}, '0);
    RESETL = 1'b1;
    @(negedge CCLK);

    prog_body(20'h01000, 8'h41);

    start_prog(20'h02000);
    parcrq_cycles = 0;
    mem_cycle(8'h00, 1'b0, 0);
    check("halt1_run", RUN, 0);
    check("halt1_comcrq", COMCRQ, 0);
    check("halt1_pc", PC, 20'h02001);
    @(negedge CCLK);
    check("halt1_no_parcrq", parcrq_cycles, 0);

    start_prog(20'hFFFFF);
    mem_cycle(8'h00, 1'b0, 0);
    check("pc_wrap", PC, 20'h00000);

    PCIN = 20'h07777; START = 1'b1; ABORT = 1'b1;
    @(negedge CCLK);
    START = 1'b0; ABORT = 1'b0;
    check("start_abort_run", RUN, 0);
    check("start_abort_pc", PC, 20'h00000);

    start_prog(20'h03000);
    parld_cnt = 0;
    mem_cycle(8'h40, 1'b0, 0);
    for (int i = 0; i < 5; i++) mem_cycle(8'(i + 1), 1'b1, i);
    for (int n = 0; n < 20 && PARCRQ !== 1'b1; n++) @(negedge CCLK);
    check("abort_req_ready", PARCRQ, 1);
    CYCEND = 1'b1; PCEN = 1'b1; UPDPCL = 1'b0; DATA = 8'h06; ABORT = 1'b1;
    @(negedge CCLK);
    CYCEND = 1'b0; PCEN = 1'b0; UPDPCL = 1'b1; ABORT = 1'b0;
    check("abort_reqs", {COMCRQ, PARCRQ, RUN}, 3'b000);
    check("abort_pc", PC, 20'h03006);
    check("abort_cmd", CMD, 8'h40);
    repeat (3) @(negedge CCLK);
    check("abort_parld_count", parld_cnt, 5);
    check("abort_paridx", PARIDX, 4'd4);

    start_prog(20'h05000);
    mem_cycle(8'h40, 1'b0, 0);
    mem_cycle(8'h01, 1'b1, 0);
    mem_cycle(8'h02, 1'b1, 1);
    #2 RESETL = 1'b0;
    #1 check("async_reset", {COMCRQ, PARCRQ, PARLD, INSTART, RUN, PC, CMD, PARD, PARIDX}, '0);
    @(negedge CCLK);
    RESETL = 1'b1;
    @(negedge CCLK);
    check("reset_sb_drained", sb.size(), 0);

    prog_body(20'h04000, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
